// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - opcodes, register map, command indices and FSM encoding for the accelerometer sequencer
package accel_pkg;

  localparam logic [7:0] WRITE = 8'h0A;
  localparam logic [7:0] READ  = 8'h0B;
  localparam logic [7:0] OFF   = 8'hFF;

  localparam logic [7:0] SOFT_RESET = 8'h1F;
  localparam logic [7:0] FILTER_CTL = 8'h2C;
  localparam logic [7:0] POWER_CTL  = 8'h2D;
  localparam logic [7:0] XDATA      = 8'h08;
  localparam logic [7:0] YDATA      = 8'h09;
  localparam logic [7:0] ZDATA      = 8'h0A;

  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  localparam logic [2:0] IDX_POWER = 3'd2;
  localparam logic [2:0] IDX_X     = 3'd3;
  localparam logic [2:0] IDX_Y     = 3'd4;
  localparam logic [2:0] IDX_Z     = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    ADVANCE,
    POLL_WAIT,
    ERROR
  } state_t;

endpackage

// File: rtl/accel_cmd_rom.sv
// rtl/accel_cmd_rom.sv - command list: index to {instruction, address, data}
module accel_cmd_rom
  import accel_pkg::*;
#(
  parameter int                   CMDLENGTH  = 8,
  parameter logic [CMDLENGTH-1:0] FILTER_CFG = 8'h13,
  parameter logic [CMDLENGTH-1:0] POWER_CFG  = 8'h02
) (
  input  logic [2:0]           idx,
  output logic [CMDLENGTH-1:0] instr,
  output logic [CMDLENGTH-1:0] addr,
  output logic [CMDLENGTH-1:0] data
);

  always_comb begin
    instr = CMDLENGTH'(OFF);
    addr  = '0;
    data  = '0;
    case (idx)
      3'd0: begin
        instr = CMDLENGTH'(WRITE);
        addr  = CMDLENGTH'(SOFT_RESET);
        data  = CMDLENGTH'(SOFT_RESET_KEY);
      end
      3'd1: begin
        instr = CMDLENGTH'(WRITE);
        addr  = CMDLENGTH'(FILTER_CTL);
        data  = FILTER_CFG;
      end
      3'd2: begin
        instr = CMDLENGTH'(WRITE);
        addr  = CMDLENGTH'(POWER_CTL);
        data  = POWER_CFG;
      end
      3'd3: begin
        instr = CMDLENGTH'(READ);
        addr  = CMDLENGTH'(XDATA);
      end
      3'd4: begin
        instr = CMDLENGTH'(READ);
        addr  = CMDLENGTH'(YDATA);
      end
      3'd5: begin
        instr = CMDLENGTH'(READ);
        addr  = CMDLENGTH'(ZDATA);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accel_sequencer.sv
// rtl/accel_sequencer.sv - accelerometer bring-up and X/Y/Z polling sequencer above the SPI command handler
module accel_sequencer
  import accel_pkg::*;
#(
  parameter int                   CMDLENGTH      = 8,
  parameter int                   POLL_DIV       = 2000000,
  parameter logic [CMDLENGTH-1:0] FILTER_CFG     = 8'h13,
  parameter logic [CMDLENGTH-1:0] POWER_CFG      = 8'h02,
  parameter int                   ACCEPT_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 i_CMD_Ready,
  input  logic [CMDLENGTH-1:0] i_CMD_Data,
  output logic [CMDLENGTH-1:0] o_CMD_Instruction,
  output logic [CMDLENGTH-1:0] o_CMD_Address,
  output logic [CMDLENGTH-1:0] o_CMD_Data,
  output logic [CMDLENGTH-1:0] o_X,
  output logic [CMDLENGTH-1:0] o_Y,
  output logic [CMDLENGTH-1:0] o_Z,
  output logic                 o_Sample_Valid,
  output logic                 o_Init_Done,
  output logic                 o_Error
);

  localparam int CNT_MAX = (POLL_DIV > ACCEPT_TIMEOUT) ? POLL_DIV : ACCEPT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [CMDLENGTH-1:0] instr_q, instr_d;
  logic [CMDLENGTH-1:0] addr_q, addr_d;
  logic [CMDLENGTH-1:0] data_q, data_d;
  logic [CMDLENGTH-1:0] stage_x_q, stage_x_d, stage_y_q, stage_y_d, stage_z_q, stage_z_d;
  logic [CMDLENGTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                 valid_q, valid_d;
  logic                 init_q, init_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     wd_q, wd_d, poll_q, poll_d;
  logic [CNT_W-1:0]     wd_inc, poll_inc;
  logic [CMDLENGTH-1:0] rom_instr, rom_addr, rom_data;

  accel_cmd_rom #(
    .CMDLENGTH (CMDLENGTH),
    .FILTER_CFG(FILTER_CFG),
    .POWER_CFG (POWER_CFG)
  ) u_rom (
    .idx  (idx_q),
    .instr(rom_instr),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign wd_inc   = wd_q + CNT_W'(1);
  assign poll_inc = poll_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    stage_x_d = stage_x_q;
    stage_y_d = stage_y_q;
    stage_z_d = stage_z_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    valid_d   = 1'b0;
    init_d    = init_q;
    err_d     = err_q;
    wd_d      = wd_q;
    poll_d    = poll_q;
    case (state_q)
      IDLE: begin
        instr_d = CMDLENGTH'(OFF);
        // Bus registers load here so the command is already visible during ISSUE.
        if (enable && i_CMD_Ready) begin
          instr_d = rom_instr;
          addr_d  = rom_addr;
          data_d  = rom_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!i_CMD_Ready) begin
          instr_d = CMDLENGTH'(OFF);
          state_d = WAIT_DONE;
        end else if (wd_inc == CNT_W'(ACCEPT_TIMEOUT)) begin
          wd_d    = wd_inc;
          instr_d = CMDLENGTH'(OFF);
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      WAIT_DONE: begin
        if (i_CMD_Ready) begin
          if (idx_q == IDX_X) stage_x_d = i_CMD_Data;
          if (idx_q == IDX_Y) stage_y_d = i_CMD_Data;
          if (idx_q == IDX_Z) stage_z_d = i_CMD_Data;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        // Publish only complete triples; partial samples stay in staging.
        if (idx_q == IDX_Z) begin
          x_d     = stage_x_q;
          y_d     = stage_y_q;
          z_d     = stage_z_q;
          valid_d = 1'b1;
          poll_d  = '0;
          state_d = POLL_WAIT;
        end else begin
          if (idx_q == IDX_POWER) init_d = 1'b1;
          idx_d   = idx_q + 3'd1;
          state_d = IDLE;
        end
      end
      POLL_WAIT: begin
        poll_d = poll_inc;
        if (poll_inc == CNT_W'(POLL_DIV)) begin
          idx_d   = IDX_X;
          state_d = IDLE;
        end
      end
      ERROR: begin
        instr_d = CMDLENGTH'(OFF);
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      instr_q   <= CMDLENGTH'(OFF);
      addr_q    <= '0;
      data_q    <= '0;
      stage_x_q <= '0;
      stage_y_q <= '0;
      stage_z_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      valid_q   <= 1'b0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      stage_x_q <= stage_x_d;
      stage_y_q <= stage_y_d;
      stage_z_q <= stage_z_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
      init_q    <= init_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      poll_q    <= poll_d;
    end
  end

  assign o_CMD_Instruction = instr_q;
  assign o_CMD_Address     = addr_q;
  assign o_CMD_Data        = data_q;
  assign o_X               = x_q;
  assign o_Y               = y_q;
  assign o_Z               = z_q;
  assign o_Sample_Valid    = valid_q;
  assign o_Init_Done       = init_q;
  assign o_Error           = err_q;

endmodule

// File: doc/accel_sequencer.md
# accel_sequencer

Autonomous command sequencer that sits above the SPI command handler and drives its instruction/address/data bus. After reset it runs the accelerometer bring-up: soft reset, filter configuration, then power-up into measurement mode. It then polls the X, Y and Z 8-bit data registers at a fixed rate and publishes each complete sample to the rest of the design with a one-cycle valid strobe.

## Interface
Parameters:
- CMDLENGTH, 8, width of the instruction, address and data bytes.
- POLL_DIV, 2000000, clk cycles between the end of one sample and the start of the next X read.
- FILTER_CFG, 8'h13, value written to FILTER_CTL (0x2C).
- POWER_CFG, 8'h02, value written to POWER_CTL (0x2D).
- ACCEPT_TIMEOUT, 65535, clk cycles allowed for the handler to leave ready after a command is presented.

Ports:
- clk  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new commands to be issued; an in-flight command always completes.
- i_CMD_Ready  in  1  handler idle and not stalled.
- i_CMD_Data  in  CMDLENGTH  read-back byte from the handler.
- o_CMD_Instruction  out  CMDLENGTH  0x0A write, 0x0B read, 0xFF no command.
- o_CMD_Address  out  CMDLENGTH  register address.
- o_CMD_Data  out  CMDLENGTH  write data; 0x00 for reads.
- o_X, o_Y, o_Z  out  CMDLENGTH each  last complete sample.
- o_Sample_Valid  out  1  one-cycle pulse when o_X/o_Y/o_Z update.
- o_Init_Done  out  1  high once POWER_CTL has completed; stays high until reset.
- o_Error  out  1  sticky; a handler accept timeout occurred.

## Operation
- Command list, index 0-5: 0 write 0x1F←0x52; 1 write 0x2C←FILTER_CFG; 2 write 0x2D←POWER_CFG; 3 read 0x08 (X); 4 read 0x09 (Y); 5 read 0x0A (Z).
- FSM states are IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, ADVANCE, POLL_WAIT and ERROR.
- IDLE: the instruction is 0xFF. Move to ISSUE when enable is high and i_CMD_Ready is high.
- ISSUE: drive the command for the current index. Move to WAIT_ACCEPT.
- WAIT_ACCEPT: hold the command on the bus. When i_CMD_Ready falls, the command is accepted: set the instruction to 0xFF and go to WAIT_DONE. The watchdog counts cycles here. When it reaches ACCEPT_TIMEOUT, go to ERROR.
- WAIT_DONE: wait for i_CMD_Ready to rise. The handler has then completed the command, including its stall period. For reads, capture i_CMD_Data into a staging register for that axis. Go to ADVANCE.
- ADVANCE:
  - index <3: increment the index. Set o_Init_Done when index 2 completes. Go to IDLE.
  - index 3 or 4: increment the index and go to IDLE.
  - index 5: copy the staged bytes to o_X/o_Y/o_Z, pulse o_Sample_Valid, load the poll counter and go to POLL_WAIT.
- POLL_WAIT: count POLL_DIV cycles, then set the index to 3 and go to IDLE.
- ERROR: the instruction is 0xFF and o_Error=1. Only reset leaves this state.
- Boundaries:
  - Outputs update only as a triple, so a partial sample is never visible.
  - If enable falls mid-command, the command finishes and the FSM parks in IDLE with the index preserved.
  - If enable falls in POLL_WAIT, counting continues, then the FSM parks in IDLE.
  - Reset at any point aborts the sequence and restarts it from index 0.

## Timing
- Reset values: state IDLE, index 0, instruction 0xFF, address 0x00, data 0x00, o_X/o_Y/o_Z 0x00, o_Sample_Valid 0, o_Init_Done 0, o_Error 0, counters 0.
- All outputs are registered.
- The command appears on the bus 1 cycle after IDLE sees enable && i_CMD_Ready.
- o_Sample_Valid is high for exactly 1 cycle, in the same cycle o_X/o_Y/o_Z first show the new values. That cycle is 2 clk after the i_CMD_Ready rise that ends the Z read.
- Sample period = POLL_DIV + the handler time for 3 reads + fixed FSM overhead of 4 cycles per command.
- The poll and watchdog counters are sized $clog2(max(POLL_DIV, ACCEPT_TIMEOUT)+1). They count up, compare for equality, and never wrap.

## Structure
- Shared package accel_pkg:
  - opcodes READ=0x0B, WRITE=0x0A, OFF=0xFF;
  - register addresses SOFT_RESET=0x1F, FILTER_CTL=0x2C, POWER_CTL=0x2D, XDATA=0x08, YDATA=0x09, ZDATA=0x0A;
  - soft-reset key 0x52;
  - the FSM state encoding.
- One sub-module, accel_cmd_rom: combinational map from index → {instruction, address, data}, parameterised with FILTER_CFG and POWER_CFG.

## Test plan
- Bring-up: reset, enable=1, behavioural handler model (ready drops 2 cycles after a command is presented, rises 20 cycles later) → bus sequence (0x0A,0x1F,0x52), (0x0A,0x2C,0x13), (0x0A,0x2D,0x02); o_Init_Done=1 after the third.
- Poll: model returns 0x11, 0x22, 0x33 for the X/Y/Z reads, POLL_DIV=100 → o_X=0x11, o_Y=0x22, o_Z=0x33 with one o_Sample_Valid pulse; the next X read appears 100 cycles plus overhead later.
- Enable drop: deassert enable during the Y read → Y completes, the bus stays 0xFF, no pulse; re-enable → the Z read is issued next and the sample completes.
- Watchdog: ACCEPT_TIMEOUT=50, model never drops ready → o_Error=1 at cycle 50 of WAIT_ACCEPT; the bus stays 0xFF until reset.
- Reset mid-sample: reset during the Z read → all outputs return to reset values; the next commands are the index-0 soft reset; o_X is unchanged from 0x00 until a full triple completes.
